// File: rtl/uc_if_pkg.sv
// Shared definitions for the control-unit instruction handshake: word width
// and the issuer FSM state encoding.
package uc_if_pkg;

    localparam int INSTR_W = 26;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_REQ_ENC     = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC    = 2'd2;
    localparam logic [1:0] ST_RELEASE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_REQ     = ST_REQ_ENC,
        ST_WAIT    = ST_WAIT_ENC,
        ST_RELEASE = ST_RELEASE_ENC
    } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO; a word written at one edge is visible at the head after it.
// Backpressure: push is refused while full, even if a pop happens in the same cycle.
module instr_fifo
    import uc_if_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = INSTR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_issuer.sv
// Queues host instruction words and issues them one at a time over the UC req/done
// handshake; first request 1 cycle after the push edge. Host backpressure: cmd_ready = !full.
module instruction_issuer
    import uc_if_pkg::*;
#(
    parameter int          DEPTH          = 8,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [15:0] DONE_CNT_RST   = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    input  logic [INSTR_W-1:0]         cmd_instr,
    output logic                       cmd_ready,
    output logic [INSTR_W-1:0]         uc_instr,
    output logic                       uc_req,
    input  logic                       uc_done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       done_pulse,
    output logic [15:0]                done_count,
    output logic                       timeout_err,
    input  logic                       err_clr
);

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [INSTR_W-1:0]   r_uc_instr;
    logic [INSTR_W-1:0]   w_instr_nxt;
    logic                 r_uc_req;
    logic                 w_req_nxt;
    logic                 r_done_pulse;
    logic                 w_pulse_nxt;
    logic [15:0]          r_done_cnt;
    logic [15:0]          w_done_cnt_nxt;
    logic                 r_tmo_err;
    logic                 w_tmo_set;
    logic [TW-1:0]        r_tmo_cnt;
    logic [TW-1:0]        w_tmo_cnt_nxt;
    logic                 w_tmo_hit;

    logic                 w_fifo_pop;
    logic [INSTR_W-1:0]   w_fifo_dat;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd_valid),
        .i_dat   (cmd_instr),
        .i_pop   (w_fifo_pop),
        .o_dat   (w_fifo_dat),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_tmo_hit = TMO_EN && (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_fifo_pop     = 1'b0;
        w_instr_nxt    = r_uc_instr;
        w_req_nxt      = r_uc_req;
        w_pulse_nxt    = 1'b0;
        w_done_cnt_nxt = r_done_cnt;
        w_tmo_set      = 1'b0;
        w_tmo_cnt_nxt  = r_tmo_cnt + 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_tmo_cnt_nxt = '0;
                if (!w_fifo_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_instr_nxt = w_fifo_dat;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            // A done level still high here is left over from the previous transfer.
            ST_REQ: begin
                if (w_tmo_hit) begin
                    w_req_nxt   = 1'b0;
                    w_tmo_set   = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else if (!uc_done) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (uc_done) begin
                    w_req_nxt      = 1'b0;
                    w_pulse_nxt    = 1'b1;
                    w_done_cnt_nxt = r_done_cnt + 16'd1;
                    w_state_nxt    = ST_RELEASE;
                end else if (w_tmo_hit) begin
                    w_req_nxt   = 1'b0;
                    w_tmo_set   = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_req_nxt     = 1'b0;
                w_tmo_cnt_nxt = '0;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_uc_instr   <= '0;
            r_uc_req     <= 1'b0;
            r_done_pulse <= 1'b0;
            r_done_cnt   <= DONE_CNT_RST;
            r_tmo_err    <= 1'b0;
            r_tmo_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_uc_instr   <= w_instr_nxt;
            r_uc_req     <= w_req_nxt;
            r_done_pulse <= w_pulse_nxt;
            r_done_cnt   <= w_done_cnt_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            // A new timeout outranks a simultaneous clear so no event is lost.
            if (w_tmo_set) begin
                r_tmo_err <= 1'b1;
            end else if (err_clr) begin
                r_tmo_err <= 1'b0;
            end
        end
    end

    assign cmd_ready   = !w_fifo_full;
    assign uc_instr    = r_uc_instr;
    assign uc_req      = r_uc_req;
    assign busy        = (r_state != ST_IDLE) || !w_fifo_empty;
    assign fifo_count  = w_fifo_count;
    assign done_pulse  = r_done_pulse;
    assign done_count  = r_done_cnt;
    assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed bench for instruction_issuer with a behavioural control-unit model
// that captures on req, answers after a set latency and leaves done high.
module tb_instruction_issuer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [25:0] cmd_instr;
    logic        cmd_ready;
    logic [25:0] uc_instr;
    logic        uc_req;
    logic        uc_done;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        done_pulse;
    logic [15:0] done_count;
    logic        timeout_err;
    logic        err_clr;

    logic        cmd_ready_w;
    logic [25:0] uc_instr_w;
    logic        uc_req_w;
    logic        busy_w;
    logic [3:0]  fifo_count_w;
    logic        done_pulse_w;
    logic [15:0] done_count_w;
    logic        timeout_err_w;

    int checks = 0;
    int errors = 0;

    int          lat;
    logic [25:0] cap[$];
    logic        m_armed;
    logic        m_pend;
    logic        m_active;
    int          m_cnt;
    int          dp_cnt;
    int          min_gap;
    int          low_run;
    logic        seen_req;

    instruction_issuer #(
        .DEPTH          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_instr   (cmd_instr),
        .cmd_ready   (cmd_ready),
        .uc_instr    (uc_instr),
        .uc_req      (uc_req),
        .uc_done     (uc_done),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .done_pulse  (done_pulse),
        .done_count  (done_count),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    // Twin instance fed identically, but with the completion counter starting at 0xFFFE.
    instruction_issuer #(
        .DEPTH          (8),
        .TIMEOUT_CYCLES (16),
        .DONE_CNT_RST   (16'hFFFE)
    ) dut_w (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_instr   (cmd_instr),
        .cmd_ready   (cmd_ready_w),
        .uc_instr    (uc_instr_w),
        .uc_req      (uc_req_w),
        .uc_done     (uc_done),
        .busy        (busy_w),
        .fifo_count  (fifo_count_w),
        .done_pulse  (done_pulse_w),
        .done_count  (done_count_w),
        .timeout_err (timeout_err_w),
        .err_clr     (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UC model: capture on the second cycle req is seen high, then done after lat cycles.
    initial begin
        uc_done  = 1'b0;
        m_armed  = 1'b1;
        m_pend   = 1'b0;
        m_active = 1'b0;
        m_cnt    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                uc_done  = 1'b0;
                m_armed  = 1'b1;
                m_pend   = 1'b0;
                m_active = 1'b0;
                m_cnt    = 0;
            end else begin
                if (m_active) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        uc_done  = 1'b1;
                        m_active = 1'b0;
                    end
                end
                if (uc_req && m_armed) begin
                    if (!m_pend) begin
                        m_pend = 1'b1;
                    end else begin
                        m_pend   = 1'b0;
                        m_armed  = 1'b0;
                        uc_done  = 1'b0;
                        cap.push_back(uc_instr);
                        m_active = (lat != 0);
                        m_cnt    = lat;
                    end
                end else if (!uc_req) begin
                    m_armed = 1'b1;
                    m_pend  = 1'b0;
                end
            end
        end
    end

    initial begin
        dp_cnt   = 0;
        min_gap  = 99;
        low_run  = 0;
        seen_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen_req = 1'b0;
                low_run  = 0;
            end else begin
                if (done_pulse) dp_cnt++;
                if (uc_req) begin
                    if (seen_req && low_run > 0 && low_run < min_gap) min_gap = low_run;
                    seen_req = 1'b1;
                    low_run  = 0;
                end else begin
                    low_run++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (busy && n < lim) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(busy), 32'h0);
    endtask

    task automatic wait_req(input string tag, input int lim);
        int n = 0;
        while (!uc_req && n < lim) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(uc_req), 32'h1);
    endtask

    task automatic push1(input logic [25:0] w);
        cmd_valid = 1'b1;
        cmd_instr = w;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_instr = '0;
        err_clr   = 1'b0;
        lat       = 3;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        chk("rst_uc_req",     32'(uc_req),      32'h0);
        chk("rst_uc_instr",   32'(uc_instr),    32'h0);
        chk("rst_cmd_ready",  32'(cmd_ready),   32'h1);
        chk("rst_busy",       32'(busy),        32'h0);
        chk("rst_fifo_count", 32'(fifo_count),  32'h0);
        chk("rst_done_pulse", 32'(done_pulse),  32'h0);
        chk("rst_done_count", 32'(done_count),  32'h0);
        chk("rst_timeout",    32'(timeout_err), 32'h0);

        // 1) single word, latency 3
        push1(26'h2ABCDEF);
        chk("t1_req_t0",   32'(uc_req),     32'h0);
        chk("t1_count_t0", 32'(fifo_count), 32'h1);
        tick(1);
        chk("t1_req_t1",   32'(uc_req),     32'h1);
        chk("t1_instr",    32'(uc_instr),   32'h2ABCDEF);
        chk("t1_count_t1", 32'(fifo_count), 32'h0);
        wait_idle("t1_idle", 50);
        chk("t1_req_low",  32'(uc_req),     32'h0);
        chk("t1_pulses",   32'(dp_cnt),     32'd1);
        chk("t1_done_cnt", 32'(done_count), 32'd1);
        chk("t1_cap_n",    32'(cap.size()), 32'd1);
        chk("t1_cap0",     32'(cap[0]),     32'h2ABCDEF);

        // 2) three words back to back
        cmd_valid = 1'b1;
        cmd_instr = 26'h1234567; tick(1);
        cmd_instr = 26'h3FFFFFF; tick(1);
        cmd_instr = 26'h0A5A5A5; tick(1);
        cmd_valid = 1'b0;
        wait_idle("t2_idle", 200);
        chk("t2_cap_n",    32'(cap.size()), 32'd4);
        chk("t2_cap1",     32'(cap[1]),     32'h1234567);
        chk("t2_cap2",     32'(cap[2]),     32'h3FFFFFF);
        chk("t2_cap3",     32'(cap[3]),     32'h0A5A5A5);
        chk("t2_pulses",   32'(dp_cnt),     32'd4);
        chk("t2_done_cnt", 32'(done_count), 32'd4);
        chk("t2_low_gap",  32'(min_gap),    32'd2);

        // 3) fill with a slow UC: one word in flight plus eight queued
        lat = 10;
        cmd_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cmd_instr = 26'h100000 + 26'(i);
            tick(1);
        end
        chk("t3_count_full", 32'(fifo_count), 32'd8);
        chk("t3_ready_full", 32'(cmd_ready),  32'h0);
        cmd_instr = 26'h1000FF;
        tick(1);
        cmd_valid = 1'b0;
        chk("t3_refused", 32'(fifo_count), 32'd8);
        n = 0;
        while (!done_pulse && n < 40) begin
            tick(1);
            n++;
        end
        chk("t3_first_done", 32'(done_pulse), 32'h1);
        lat = 3;
        tick(2);
        chk("t3_count_7", 32'(fifo_count), 32'd7);
        chk("t3_ready_1", 32'(cmd_ready),  32'h1);
        wait_idle("t3_idle", 400);
        chk("t3_done_cnt", 32'(done_count),  32'd13);
        chk("t3_cap_n",    32'(cap.size()),  32'd13);
        chk("t3_cap_head", 32'(cap[4]),      32'h100000);
        chk("t3_cap_tail", 32'(cap[12]),     32'h100008);
        chk("t3_no_tmo",   32'(timeout_err), 32'h0);

        // 4) UC never answers; timeout after 16 cycles of req
        lat = 0;
        cmd_valid = 1'b1;
        cmd_instr = 26'h0DEAD00; tick(1);
        cmd_instr = 26'h2000001; tick(1);
        cmd_valid = 1'b0;
        chk("t4_req_x", 32'(uc_req), 32'h1);
        n = 0;
        while (uc_req && n < 40) begin
            n++;
            tick(1);
        end
        chk("t4_req_cycles", 32'(n),           32'd16);
        chk("t4_tmo_set",    32'(timeout_err), 32'h1);
        chk("t4_done_cnt",   32'(done_count),  32'd13);
        chk("t4_pulses",     32'(dp_cnt),      32'd13);
        wait_req("t4_req_y", 10);
        chk("t4_instr_y", 32'(uc_instr), 32'h2000001);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t4_clr", 32'(timeout_err), 32'h0);
        tick(14);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t4_set_wins",   32'(timeout_err), 32'h1);
        chk("t4_req_drop_y", 32'(uc_req),      32'h0);
        wait_idle("t4_idle", 20);
        chk("t4_done_cnt_y", 32'(done_count), 32'd13);

        // 5) reset while waiting for done with four words queued
        lat = 10;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_instr = 26'h300000 + 26'(i);
            tick(1);
        end
        cmd_valid = 1'b0;
        chk("t5_queued",  32'(fifo_count), 32'd4);
        chk("t5_req_pre", 32'(uc_req),     32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_req_async", 32'(uc_req),       32'h0);
        chk("t5_count",     32'(fifo_count),   32'h0);
        chk("t5_done_cnt",  32'(done_count),   32'h0);
        chk("t5_busy",      32'(busy),         32'h0);
        chk("t5_ready",     32'(cmd_ready),    32'h1);
        chk("t5_tmo_clr",   32'(timeout_err),  32'h0);
        chk("t5_w_preset",  32'(done_count_w), 32'hFFFE);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("t5_idle_busy", 32'(busy),   32'h0);
        chk("t5_idle_req",  32'(uc_req), 32'h0);
        lat = 3;
        push1(26'h155AA55);
        wait_idle("t5_idle", 50);
        chk("t5_done_after", 32'(done_count),          32'd1);
        chk("t5_w_ffff",     32'(done_count_w),        32'hFFFF);
        chk("t5_cap_last",   32'(cap[cap.size() - 1]), 32'h155AA55);

        // 6) second completion wraps the preset counter
        push1(26'h2222222);
        wait_idle("t6_idle", 50);
        chk("t6_done_cnt", 32'(done_count),   32'd2);
        chk("t6_w_wrap",   32'(done_count_w), 32'h0000);
        chk("t6_pulses",   32'(dp_cnt),       32'd15);
        chk("t6_pulse_lo", 32'(done_pulse),   32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
